// File: rtl/rr_reg_write_arbiter.sv
// rr_reg_write_arbiter
//
// Shares one bank of DEPTH x WIDTH storage words among NREQ write
// requesters. A round-robin arbiter picks one requester at a time. A
// three-state FSM (IDLE -> GRANT -> ACK) then performs that requester's
// write. The read port is combinational.
//
// Ports:
//   clk      - clock; all state updates on the rising edge
//   rst      - synchronous, active-high reset (priority over everything)
//   req      - per-requester write request level [NREQ]
//   wr_addr  - flattened write addresses, requester i at [i*AW +: AW]
//   wr_data  - flattened write data, requester i at [i*WIDTH +: WIDTH]
//   gnt      - registered one-hot grant, high in GRANT and ACK
//   ack      - registered one-hot write-done pulse, high in ACK only
//   busy     - high whenever the FSM is not in IDLE
//   rd_addr  - read address
//   rd_data  - combinational read of the addressed storage word
module rr_reg_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    wr_addr,
  input  logic [NREQ*WIDTH-1:0] wr_data,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  input  logic [AW-1:0]         rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

  state_t            state, state_nx;
  logic [IW-1:0]     ptr, ptr_nx;
  logic [IW-1:0]     win;
  logic [IW-1:0]     pick;
  logic              pick_valid;
  logic [NREQ-1:0]   gnt_nx, ack_nx;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  mem [DEPTH];

  // Round-robin search starting at ptr. The loop walks from the farthest
  // candidate back to ptr so the candidate nearest to ptr is written last
  // and therefore wins.
  always_comb begin
    int idx;
    pick       = '0;
    pick_valid = 1'b0;
    idx        = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        pick       = IW'(idx);
        pick_valid = 1'b1;
      end
    end
  end

  // The address and data of the registered winner drive the single write
  // port of the storage bank.
  always_comb begin
    waddr = wr_addr[int'(win)*AW +: AW];
    wdata = wr_data[int'(win)*WIDTH +: WIDTH];
  end

  // Next-state logic. gnt and ack are registered, so their next values are
  // computed here from the transition being taken. req is looked at only in
  // IDLE, which makes requests that arrive in GRANT or ACK wait for the
  // following IDLE cycle.
  always_comb begin
    state_nx = state;
    gnt_nx   = '0;
    ack_nx   = '0;
    we       = 1'b0;
    ptr_nx   = ptr;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nx     = GRANT;
          gnt_nx[pick] = 1'b1;
        end
      end
      GRANT: begin
        state_nx    = ACK;
        we          = 1'b1;
        gnt_nx[win] = 1'b1;
        ack_nx[win] = 1'b1;
      end
      ACK: begin
        state_nx = IDLE;
        ptr_nx   = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control state. The winner is latched at the end of arbitration so
  // that later changes on req cannot disturb the transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      win   <= '0;
      gnt   <= '0;
      ack   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      gnt   <= gnt_nx;
      ack   <= ack_nx;
      if (state == IDLE && pick_valid) win <= pick;
    end
  end

  // Storage words. The write happens at the edge that closes GRANT, so a
  // read of that address during GRANT still returns the old value. Reset
  // wins over a write in flight, so an aborted transaction leaves memory
  // cleared rather than updated.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign busy    = (state != IDLE);
  assign rd_data = mem[rd_addr];

endmodule
